// File: rtl/nibble_sub_pkg.sv
// Shared definitions for the nibble-serial subtractor.
//   NIB_W        - width of one processed digit (4 bits)
//   sub_state_t  - controller states IDLE / RUN / DONE
//   num_nibbles  - number of digits in an operand of the given width
package nibble_sub_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_t;

    function automatic int num_nibbles(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/nibble_serial_subtractor_sub4.sv
// One 4-bit subtract-with-borrow cell, purely combinational.
// Ports:
//   a, b  - minuend / subtrahend digit
//   bin   - borrow in from the less significant digit
//   d     - difference digit (a - b - bin mod 16)
//   bout  - borrow out, set when a < b + bin
module sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [4:0] t;

    // Computed one bit wider: a negative result wraps to 5'b1xxxx,
    // so the top bit is the borrow out.
    assign t    = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
    assign d    = t[3:0];
    assign bout = t[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor: diff = dataA - dataB (mod 2^WIDTH), one nibble per
// clock, LSB nibble first, with a valid/ready handshake on each side.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   dataA, dataB        - minuend / subtrahend, sampled on the accept edge
//   in_valid, in_ready  - operand handshake (ready only in IDLE)
//   diff, borrow        - result and final borrow (dataA < dataB unsigned)
//   out_valid, out_ready- result handshake (valid only in DONE)
// Build option: define NIBBLE_SUB_SAT_EN to make diff read as 0 in DONE
// whenever the final borrow is set (unsigned saturation).
module nibble_serial_subtractor
    import nibble_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NN    = num_nibbles(WIDTH);
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic             brw_q;
    logic [IDX_W-1:0] idx_q;

    logic       accept, last_nib;
    logic [3:0] a_nib, b_nib, d_nib;
    logic       bout;

    assign accept   = (state_q == IDLE) && in_valid;
    assign last_nib = (idx_q == IDX_W'(NN - 1));

    assign a_nib = a_q[idx_q*NIB_W +: NIB_W];
    assign b_nib = b_q[idx_q*NIB_W +: NIB_W];

    sub4 u_sub4 (
        .a    (a_nib),
        .b    (b_nib),
        .bin  (brw_q),
        .d    (d_nib),
        .bout (bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_nib)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Operands are held in private copies so the caller may change the
    // inputs as soon as the accept edge has passed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            brw_q  <= 1'b0;
            idx_q  <= '0;
        end else if (accept) begin
            a_q   <= dataA;
            b_q   <= dataB;
            brw_q <= 1'b0;
            idx_q <= '0;
        end else if (state_q == RUN) begin
            diff_q[idx_q*NIB_W +: NIB_W] <= d_nib;
            brw_q                        <= bout;
            idx_q                        <= last_nib ? '0 : idx_q + IDX_W'(1);
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    // After the MSB nibble the running borrow is the final borrow.
    assign borrow    = brw_q;

`ifdef NIBBLE_SUB_SAT_EN
    assign diff = ((state_q == DONE) && brw_q) ? '0 : diff_q;
`else
    assign diff = diff_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
module tb_nibble_serial_subtractor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] dataA, dataB;
    logic         in_valid, out_ready;
    logic         in_ready, out_valid, borrow;
    logic [W-1:0] diff;

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dataA     (dataA),
        .dataB     (dataB),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .borrow    (borrow),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    logic [W:0] sb[$];   // {borrow, diff}

    // Whole-word reference, independent of the nibble datapath.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] full;
        full = {1'b0, a} - {1'b0, b};
`ifdef NIBBLE_SUB_SAT_EN
        if (full[W]) full[W-1:0] = '0;
`endif
        return full;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b);
        dataA    = a;
        dataB    = b;
        in_valid = 1'b1;
        chk("accept in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        sb.push_back(model(a, b));
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_out(input string tag);
        logic [W:0] e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: got unexpected result %0h expected none", tag, diff);
        end else begin
            e = sb.pop_front();
            chk({tag, " diff"}, 32'(diff), 32'(e[W-1:0]));
            chk({tag, " borrow"}, 32'(borrow), 32'(e[W]));
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cyc, last_acc, pushed, popped;
        logic acc;
        logic [W:0] e;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dataA = '0; dataB = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst in_ready",  32'(in_ready),  32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst diff",      32'(diff),      32'd0);
        chk("rst borrow",    32'(borrow),    32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // Basic op with exact latency
        do_accept(16'h1234, 16'h0234);
        wait_valid(lat);
        chk("s1 latency", 32'(lat), 32'd4);
        chk("s1 diff const", 32'(diff), 32'h1000);
        check_out("s1");
        finish_op();
        chk("s1 in_ready after", 32'(in_ready), 32'd1);
        chk("s1 out_valid after", 32'(out_valid), 32'd0);

        // Wrap-around 0 - 1
        do_accept(16'h0000, 16'h0001);
        wait_valid(lat);
        chk("s2 latency", 32'(lat), 32'd4);
`ifdef NIBBLE_SUB_SAT_EN
        chk("s2 diff const", 32'(diff), 32'h0000);
`else
        chk("s2 diff const", 32'(diff), 32'hFFFF);
`endif
        chk("s2 borrow const", 32'(borrow), 32'd1);
        check_out("s2");
        finish_op();

        // Borrow ripples across three nibbles
        do_accept(16'h8000, 16'h0001);
        wait_valid(lat);
        chk("s3 diff const", 32'(diff), 32'h7FFF);
        chk("s3 borrow const", 32'(borrow), 32'd0);
        check_out("s3");
        finish_op();

        // Equal operands
        do_accept(16'hBEEF, 16'hBEEF);
        wait_valid(lat);
        chk("eq diff const", 32'(diff), 32'h0000);
        check_out("eq");
        finish_op();

        // Hold in DONE with stray in_valid pulses
        do_accept(16'h1234, 16'hABCD);
        wait_valid(lat);
        chk("s4 latency", 32'(lat), 32'd4);
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            dataA    = W'($urandom);
            dataB    = W'($urandom);
            tick();
            chk("s4 hold out_valid", 32'(out_valid), 32'd1);
            chk("s4 hold diff",      32'(diff),      32'(e[W-1:0]));
            chk("s4 hold borrow",    32'(borrow),    32'(e[W]));
        end
        in_valid = 1'b0;
        finish_op();
        chk("s4 in_ready", 32'(in_ready), 32'd1);
        chk("s4 out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s4 no queued op", 32'(in_ready), 32'd1);
        end

        // Reset during RUN at nibble 2
        do_accept(16'hFFFF, 16'h1111);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("s5 rst in_ready",  32'(in_ready),  32'd1);
        chk("s5 rst out_valid", 32'(out_valid), 32'd0);
        chk("s5 rst diff",      32'(diff),      32'd0);
        chk("s5 rst borrow",    32'(borrow),    32'd0);
        tick();
        tick();
        chk("s5 no pulse", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s5 aborted stays idle", 32'(out_valid), 32'd0);
        end
        do_accept(16'h0005, 16'h0003);
        wait_valid(lat);
        chk("s5 latency", 32'(lat), 32'd4);
        chk("s5 diff const", 32'(diff), 32'h0002);
        check_out("s5");
        finish_op();

        // Back-to-back with both handshakes held high
        in_valid = 1'b1; out_ready = 1'b1;
        dataA = W'($urandom); dataB = W'($urandom);
        cyc = 0; last_acc = -1; pushed = 0; popped = 0;
        while (popped < 1000 && cyc < 8000) begin
            if (out_valid) begin
                check_out("b2b");
                popped++;
            end
            acc = in_ready && in_valid;
            tick();
            cyc++;
            if (acc) begin
                sb.push_back(model(dataA, dataB));
                if (last_acc >= 0) chk("b2b interval", 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                pushed++;
                if (pushed == 1000) in_valid = 1'b0;
                else begin
                    dataA = W'($urandom);
                    dataB = W'($urandom);
                end
            end
        end
        chk("b2b results", 32'(popped), 32'd1000);
        out_ready = 1'b0;
        chk("sb drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
